// File: rtl/hood_timer_scheduler.sv
// Shares one seconds countdown among the three timed range-hood activities.
// Define HOOD_TIMER_PREEMPT_EN to let a higher-priority request preempt the owner.
module hood_timer_scheduler #(
  parameter int TICKS_PER_SEC = 100,
  parameter int CLEAN_SEC     = 3,
  parameter int LVL3_SEC      = 60,
  parameter int OFF_SEC       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       power_on,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       busy,
  output logic [7:0] remain_sec,
  output logic [2:0] preempted
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] SUB_LAST = 8'(TICKS_PER_SEC - 1);

  state_t     state, state_nx;
  logic [2:0] armed, armed_nx;
  logic [2:0] grant_nx, done_nx, pre_nx;
  logic [2:0] elig, pick;
  logic       busy_nx;
  logic [7:0] remain_nx;
  logic [7:0] sub_cnt, sub_nx;

  function automatic logic [7:0] dur(input logic [2:0] g);
    logic [7:0] d;
    d = '0;
    unique case (1'b1)
      g[0]:    d = 8'(CLEAN_SEC);
      g[1]:    d = 8'(LVL3_SEC);
      g[2]:    d = 8'(OFF_SEC);
      default: d = '0;
    endcase
    return d;
  endfunction

  assign elig = req & armed;
  assign pick = elig & (~elig + 3'd1);

`ifdef HOOD_TIMER_PREEMPT_EN
  logic [2:0] above, seize;
  // grant is one-hot, so grant-1 masks every higher-priority index
  assign above = elig & (grant - 3'd1);
  assign seize = above & (~above + 3'd1);
`endif

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    done_nx   = '0;
    pre_nx    = '0;
    busy_nx   = busy;
    remain_nx = remain_sec;
    sub_nx    = sub_cnt;
    armed_nx  = armed | ~req;
    unique case (state)
      IDLE: begin
        if (pick != 3'b000) begin
          grant_nx  = pick;
          remain_nx = dur(pick);
          sub_nx    = '0;
          busy_nx   = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        if ((req & grant) == 3'b000) begin
          grant_nx  = '0;
          busy_nx   = 1'b0;
          remain_nx = '0;
          sub_nx    = '0;
          state_nx  = IDLE;
        end
`ifdef HOOD_TIMER_PREEMPT_EN
        else if (seize != 3'b000) begin
          pre_nx    = grant;
          grant_nx  = seize;
          remain_nx = dur(seize);
          sub_nx    = '0;
        end
`endif
        else if (tick) begin
          if (sub_cnt == SUB_LAST) begin
            sub_nx = '0;
            if (remain_sec <= 8'd1) begin
              done_nx   = grant;
              armed_nx  = armed_nx & ~grant;
              grant_nx  = '0;
              busy_nx   = 1'b0;
              remain_nx = '0;
              state_nx  = DONE;
            end else begin
              remain_nx = remain_sec - 8'd1;
            end
          end else begin
            sub_nx = sub_cnt + 8'd1;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || !power_on) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      preempted  <= '0;
      busy       <= 1'b0;
      remain_sec <= '0;
      sub_cnt    <= '0;
      armed      <= 3'b111;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      done       <= done_nx;
      preempted  <= pre_nx;
      busy       <= busy_nx;
      remain_sec <= remain_nx;
      sub_cnt    <= sub_nx;
      armed      <= armed_nx;
    end
  end

endmodule
